// File: rtl/div_unit.sv
// div_unit: iterative radix-4 integer divider, DATA_W/2 steps plus one sign-fix cycle.
// Define DIV_SIGNED_EN to enable two's-complement mode; otherwise every divide is unsigned.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst,
  input  logic                  div_start_i,
  input  logic                  div_signed_i,
  input  logic                  div_cancel_i,
  input  logic [DATA_W-1:0]     div_opdata1_i,
  input  logic [DATA_W-1:0]     div_opdata2_i,
  output logic                  div_busy_o,
  output logic                  div_ready_o,
  output logic                  div_by_zero_o,
  output logic [2*DATA_W-1:0]   div_res_o
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W / 2 - 1);
  typedef enum logic [2:0] {IDLE, ON, DZERO, SIGN, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] quo, rem, dvs, a_mag, b_mag, fin_q, fin_r, rem_nx;
  logic [DATA_W+1:0] pr, d1, d2, d3, sub;
  logic [CW-1:0] cnt;
  logic [1:0] qd;
  logic accept;
  assign accept = state == IDLE && div_start_i && !div_cancel_i;
`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign a_mag = div_signed_i && div_opdata1_i[DATA_W-1] ? -div_opdata1_i : div_opdata1_i;
  assign b_mag = div_signed_i && div_opdata2_i[DATA_W-1] ? -div_opdata2_i : div_opdata2_i;
  assign fin_q = neg_q ? -quo : quo;
  assign fin_r = neg_r ? -rem : rem;
  always_ff @(posedge cpu_clk_50M)
    if (cpu_rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= div_signed_i && (div_opdata1_i[DATA_W-1] ^ div_opdata2_i[DATA_W-1]);
      neg_r <= div_signed_i && div_opdata1_i[DATA_W-1];
    end
`else
  logic unused_signed;
  assign unused_signed = div_signed_i;
  assign a_mag = div_opdata1_i;
  assign b_mag = div_opdata2_i;
  assign fin_q = quo;
  assign fin_r = rem;
`endif
  // quo doubles as the dividend shift register: its top digit feeds the partial remainder
  assign pr = {rem, quo[DATA_W-1 -: 2]};
  assign d1 = {2'b00, dvs};
  assign d2 = {1'b0, dvs, 1'b0};
  assign d3 = d1 + d2;
  always_comb begin
    qd = pr >= d3 ? 2'd3 : pr >= d2 ? 2'd2 : pr >= d1 ? 2'd1 : 2'd0;
    sub = qd == 2'd3 ? d3 : qd == 2'd2 ? d2 : qd == 2'd1 ? d1 : '0;
    rem_nx = DATA_W'(pr - sub);
  end
  always_ff @(posedge cpu_clk_50M)
    if (cpu_rst) begin
      state <= IDLE;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      div_res_o <= '0;
      div_busy_o <= 1'b0;
      div_ready_o <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else if (div_cancel_i) begin
      state <= IDLE;
      div_busy_o <= 1'b0;
      div_ready_o <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (div_start_i) begin
          dvs <= b_mag;
          quo <= div_opdata2_i == '0 ? div_opdata1_i : a_mag;
          rem <= '0;
          cnt <= '0;
          div_busy_o <= 1'b1;
          state <= div_opdata2_i == '0 ? DZERO : ON;
        end
        ON: begin
          quo <= {quo[DATA_W-3:0], qd};
          rem <= rem_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= SIGN;
        end
        SIGN: begin
          div_res_o <= {fin_r, fin_q};
          div_busy_o <= 1'b0;
          div_ready_o <= 1'b1;
          state <= DONE;
        end
        DZERO: begin
          div_res_o <= {quo, {DATA_W{1'b1}}};
          div_busy_o <= 1'b0;
          div_ready_o <= 1'b1;
          div_by_zero_o <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          div_ready_o <= 1'b0;
          div_by_zero_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic reference.
module tb_div_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start, sgn, cancel, busy, ready, dz;
  logic [31:0] op1, op2;
  logic [63:0] res;
  logic rst2, start2, cancel2, busy2, ready2, dz2;
  logic [15:0] op1b, op2b;
  logic [31:0] res2;
  int vecs = 0;
  int errs = 0;

  div_unit #(.DATA_W(32)) dut (
    .cpu_clk_50M(clk), .cpu_rst(rst), .div_start_i(start), .div_signed_i(sgn),
    .div_cancel_i(cancel), .div_opdata1_i(op1), .div_opdata2_i(op2),
    .div_busy_o(busy), .div_ready_o(ready), .div_by_zero_o(dz), .div_res_o(res));

  div_unit #(.DATA_W(16)) dut16 (
    .cpu_clk_50M(clk), .cpu_rst(rst2), .div_start_i(start2), .div_signed_i(1'b0),
    .div_cancel_i(cancel2), .div_opdata1_i(op1b), .div_opdata2_i(op2b),
    .div_busy_o(busy2), .div_ready_o(ready2), .div_by_zero_o(dz2), .div_res_o(res2));

  // {div_by_zero, remainder, quotient} from plain integer arithmetic
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    logic [31:0] q, r;
    logic se;
`ifdef DIV_SIGNED_EN
    se = s;
`else
    se = 1'b0;
`endif
    if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
    if (se) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, r, q};
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string nm);
    logic [64:0] e;
    int lat;
    e = model(a, b, s);
    lat = (b == 0) ? 2 : 18;
    @(negedge clk);
    op1 = a; op2 = b; sgn = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op1 = $urandom; op2 = $urandom; sgn = ~s;
    for (int k = 1; k <= lat + 1; k++) begin
      vecs++;
      if ({busy, ready} !== {k < lat, k == lat}) begin
        errs++;
        $display("FAIL %s handshake N+%0d: busy,ready=%b%b expected %b%b", nm, k, busy, ready, k < lat, k == lat);
      end
      if (k >= lat) begin
        vecs++;
        if ({dz, res} !== {(k == lat) ? e[64] : 1'b0, e[63:0]}) begin
          errs++;
          $display("FAIL %s result N+%0d: dz=%b res=%h expected dz=%b res=%h", nm, k, dz, res, (k == lat) ? e[64] : 1'b0, e[63:0]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; sgn = 1'b0; op1 = '0; op2 = '0;
    rst2 = 1'b1; start2 = 1'b0; cancel2 = 1'b0; op1b = '0; op2b = '0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({busy, ready, dz, res, busy2, ready2, dz2, res2} !== '0) begin
      errs++;
      $display("FAIL reset outputs: %b %b %b %h / %b %b %b %h expected all zero", busy, ready, dz, res, busy2, ready2, dz2, res2);
    end
    rst = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_directed;
    run_div(32'd100, 32'd7, 1'b0, "u100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7_2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_minneg_m1");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_minneg_m1");
    run_div(32'd5, 32'd0, 1'b0, "u5_0");
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, "s-5_0");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "umax_1");
    run_div(32'd3, 32'd10, 1'b0, "u3_10");
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_div(a, b, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_cancel;
    int seen;
    @(negedge clk);
    op1 = 32'd100; op2 = 32'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL cancel_idle: busy=%b expected 0", busy); end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (ready) seen++;
      @(posedge clk); #1;
    end
    vecs++;
    if (seen != 0) begin errs++; $display("FAIL cancel_no_pulse: pulses=%0d expected 0", seen); end
    @(negedge clk);
    start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL start_with_cancel: busy=%b expected 0", busy); end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (ready) seen++;
      @(posedge clk); #1;
    end
    vecs++;
    if (seen != 0) begin errs++; $display("FAIL start_with_cancel_pulse: pulses=%0d expected 0", seen); end
    run_div(32'd100, 32'd7, 1'b0, "after_cancel");
  endtask

  task automatic test_back_to_back;
    logic exp_r;
    @(negedge clk);
    op1 = 32'd20; op2 = 32'd3; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    op1 = 32'd9; op2 = 32'd4;
    for (int k = 1; k <= 39; k++) begin
      if (k == 20) start = 1'b0;
      exp_r = (k == 18 || k == 37);
      vecs++;
      if (ready !== exp_r) begin errs++; $display("FAIL b2b_ready N+%0d: ready=%b expected %b", k, ready, exp_r); end
      if (k == 18) begin
        vecs++;
        if (res !== {32'd2, 32'd6}) begin errs++; $display("FAIL b2b_first: res=%h expected %h", res, {32'd2, 32'd6}); end
      end
      if (k == 37) begin
        vecs++;
        if (res !== {32'd1, 32'd2}) begin errs++; $display("FAIL b2b_second: res=%h expected %h", res, {32'd1, 32'd2}); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_w16;
    @(negedge clk);
    op1b = 16'hFFFF; op2b = 16'd3; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; op1b = 16'h1234; op2b = 16'd0;
    for (int k = 1; k <= 11; k++) begin
      vecs++;
      if ({busy2, ready2} !== {k < 10, k == 10}) begin
        errs++;
        $display("FAIL w16 handshake N+%0d: busy,ready=%b%b expected %b%b", k, busy2, ready2, k < 10, k == 10);
      end
      if (k == 10) begin
        vecs++;
        if ({dz2, res2} !== {1'b0, 16'h0000, 16'h5555}) begin
          errs++;
          $display("FAIL w16 result: dz=%b res=%h expected dz=0 res=00005555", dz2, res2);
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    op1b = 16'hFFFF; op2b = 16'd3; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    vecs++;
    if ({busy2, ready2, dz2, res2} !== '0) begin
      errs++;
      $display("FAIL w16 midop reset: busy=%b ready=%b dz=%b res=%h expected all zero", busy2, ready2, dz2, res2);
    end
    for (int k = 0; k < 15; k++) begin
      vecs++;
      if (ready2 !== 1'b0) begin errs++; $display("FAIL w16 post-reset pulse: ready=%b expected 0", ready2); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_cancel;
    test_back_to_back;
    test_w16;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; legal values are even and >= 4.
REQ-002 SHALL have port cpu_clk_50M  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port cpu_rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port div_start_i  in  1  request a divide; sampled only in IDLE.
REQ-005 SHALL have port div_signed_i  in  1  1 = two's-complement divide, 0 = unsigned; sampled at accept.
REQ-006 SHALL have port div_cancel_i  in  1  abort any operation (pipeline flush or exception).
REQ-007 SHALL have port div_opdata1_i  in  DATA_W  dividend; sampled at accept.
REQ-008 SHALL have port div_opdata2_i  in  DATA_W  divisor; sampled at accept.
REQ-009 SHALL have port div_busy_o  out  1  high in states ON, SIGN, DZERO.
REQ-010 SHALL have port div_ready_o  out  1  one-cycle pulse; result valid.
REQ-011 SHALL have port div_by_zero_o  out  1  high with div_ready_o when the divisor was 0.
REQ-012 SHALL have port div_res_o  out  2*DATA_W  {remainder, quotient}; remainder in the upper half.

Function
REQ-013 SHALL implement the states IDLE, ON, DZERO, SIGN and DONE, held in a registered state variable.
REQ-014 Accept in cycle N SHALL require IDLE, div_start_i=1 and div_cancel_i=0; at accept, operands, mode and operand signs SHALL be captured.
REQ-015 On accept with divisor 0, the next state SHALL be DZERO; otherwise ON, with the iteration counter cleared.
REQ-016 Signed mode SHALL divide magnitudes (|x| as DATA_W-bit unsigned); unsigned mode SHALL use operands unchanged.
REQ-017 ON SHALL perform one radix-4 step per cycle for exactly DATA_W/2 cycles:
- compare the DATA_W+2-bit partial remainder against d, 2d and 3d;
- select the largest non-negative difference and shift in 2 quotient bits.
REQ-018 After the final iteration, the state SHALL move to SIGN for one cycle:
- if signed and the operand signs differ, negate the quotient;
- if signed and the dividend was negative, negate the remainder.
REQ-019 SIGN SHALL go to DONE, and DZERO SHALL go to DONE after one cycle.
REQ-020 Timing SHALL be:
- div_ready_o high in cycle N+DATA_W/2+2 (N+18 for 32), or N+2 for divide by zero;
- DONE lasts exactly one cycle, then returns to IDLE.
REQ-021 Divide by zero SHALL produce quotient all-ones, remainder equal to the dividend, and div_by_zero_o=1, in both modes.
REQ-022 Signed most-negative / -1 SHALL produce quotient equal to the most-negative value and remainder 0, with no flag.
REQ-023 div_res_o SHALL hold the last result until the next accept or reset.
REQ-024 div_by_zero_o SHALL be 0 except in DONE.
REQ-025 div_start_i SHALL be ignored outside IDLE, and operand changes after accept SHALL have no effect.
REQ-026 A div_start_i held high through DONE SHALL be accepted in the following IDLE cycle, giving back-to-back divides.
REQ-027 div_cancel_i=1 in any state SHALL force IDLE at the next edge:
- no div_ready_o pulse SHALL be produced;
- cancel SHALL win over a simultaneous start;
- cancel in DONE SHALL not suppress that cycle's already-visible pulse.

Reset
REQ-028 cpu_rst=1 at an edge SHALL force IDLE from any state, including mid-ON, and SHALL clear counter, operands and partial remainder.
REQ-029 After reset: div_busy_o=0, div_ready_o=0, div_by_zero_o=0, div_res_o=0.
REQ-030 Reset SHALL take priority over cancel and start.

Configuration
REQ-031 Macro DIV_SIGNED_EN defined: signed mode SHALL be supported per REQ-016/018/022.
REQ-032 Macro DIV_SIGNED_EN undefined:
- div_signed_i is ignored and all divides are unsigned;
- SIGN is still traversed, so latency is unchanged;
- magnitude and negation logic is not synthesised.

Verification
REQ-033 Unsigned 100/7, accept cycle N -> div_busy_o high N+1..N+17; div_ready_o only at N+18; quotient 14, remainder 2.
REQ-034 Signed cases:
- -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF;
- 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0;
- same operands unsigned -> quotient 0, remainder 0x80000000.
REQ-035 5/0 -> div_ready_o and div_by_zero_o at N+2; quotient 0xFFFFFFFF, remainder 5.
REQ-036 Cancel at N+5 -> IDLE at N+6, no div_ready_o pulse; start plus cancel in the same cycle is not accepted; a later start gives a correct result.
REQ-037 div_start_i held high across two ops (20/3 then 9/4) -> pulses at N+18 and N+37; results {2,6} then {1,2}.
REQ-038 DATA_W=16, unsigned 0xFFFF/3 -> div_ready_o at N+10, quotient 0x5555, remainder 0; cpu_rst at N+4 -> all outputs 0 at N+5.
